// File: rtl/mux_pkg.sv
// mux_pkg: mode encoding and parameter limits shared by the stream multiplexer and its arbiter
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int MAX_N     = 16;
    localparam int MAX_WIDTH = 64;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin search starting at ptr
// Ports:
//   req       in  N     request vector
//   ptr       in  SELW  first index searched
//   gnt_valid out 1     some request found
//   gnt_idx   out SELW  first requesting index at or after ptr, modulo N
module rr_arbiter #(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_valid && req[(int'(ptr) + k) % N]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SELW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mux_n_1_stream.sv
// mux_n_1_stream: N-to-1 valid/ready stream multiplexer with fixed or round-robin selection
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   mode        0 = fixed select by sel, 1 = round-robin
//   sel         channel index in fixed mode (>= N selects nothing)
//   in_data     N*WIDTH channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid    per-channel valid
//   in_ready    per-channel ready, at most one bit set
//   out_data    registered selected word
//   out_chan    source channel of out_data (only with MUX_N_1_STREAM_CHAN_TAG_EN)
//   out_valid   output register holds a word
//   out_ready   downstream accepts the word
module mux_n_1_stream
    import mux_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
`ifdef MUX_N_1_STREAM_CHAN_TAG_EN
    output logic [SELW-1:0]    out_chan,
`endif
    input  logic               out_ready,
    output logic               out_valid
);

    logic             can_load;
    logic             gnt_ok;
    logic             rr_valid;
    logic             xfer;
    logic [SELW-1:0]  gnt;
    logic [SELW-1:0]  rr_idx;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] gnt_data;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_rr (
        .req       (in_valid),
        .ptr       (ptr_q),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    always_comb begin
        can_load = !out_valid_q || out_ready;
        gnt_ok   = (mode == MODE_RR) ? rr_valid : (int'(sel) < N);
        gnt      = (mode == MODE_RR) ? rr_idx : sel;
        in_ready = '0;
        gnt_data = '0;
        // rst_n gates ready directly so it drops during reset without a clock edge
        for (int i = 0; i < N; i++) begin
            if (int'(gnt) == i) begin
                in_ready[i] = rst_n && gnt_ok && can_load;
                gnt_data    = in_data[i*WIDTH +: WIDTH];
            end
        end
        xfer        = |(in_valid & in_ready);
        out_valid_d = xfer || (out_valid_q && !out_ready);
        out_data_d  = xfer ? gnt_data : out_data_q;
        // fixed-mode transfers leave ptr alone so round-robin resumes where it stopped
        ptr_d       = (xfer && mode == MODE_RR) ? ((int'(gnt) == N - 1) ? '0 : gnt + SELW'(1)) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef MUX_N_1_STREAM_CHAN_TAG_EN
    logic [SELW-1:0] out_chan_q, out_chan_d;

    assign out_chan_d = xfer ? gnt : out_chan_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_chan_q <= '0;
        else        out_chan_q <= out_chan_d;
    end

    assign out_chan = out_chan_q;
`endif

endmodule

// File: tb/tb_mux_n_1_stream.sv
// tb_mux_n_1_stream: directed self-checking bench for mux_n_1_stream (N=4, WIDTH=2, SELW=3)
module tb_mux_n_1_stream;

    localparam int N     = 4;
    localparam int WIDTH = 2;
    localparam int SELW  = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic               out_valid;
`ifdef MUX_N_1_STREAM_CHAN_TAG_EN
    logic [SELW-1:0]    out_chan;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_n_1_stream #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
`ifdef MUX_N_1_STREAM_CHAN_TAG_EN
        .out_chan  (out_chan),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [WIDTH-1:0] d, input logic [SELW-1:0] ch);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"}, 32'(out_data), 32'(d));
`ifdef MUX_N_1_STREAM_CHAN_TAG_EN
        chk({tag, ".chan"}, 32'(out_chan), 32'(ch));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_data   = {2'b00, 2'b11, 2'b01, 2'b10};
        in_valid  = '0;
        out_ready = 1'b0;
        tick();
        chk_out("reset", 1'b0, 2'd0, 3'd0);
        chk("reset.in_ready", 32'(in_ready), 32'h0);
        tick();
        rst_n = 1'b1;

        // fixed select: sel=2 picks ch2 (2'b11)
        sel       = 3'd2;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1 chk("fix.in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk_out("fix.load", 1'b1, 2'b11, 3'd2);
        // sel out of range selects nothing; word drains without reload
        sel      = 3'd5;
        in_valid = 4'b1111;
        #1 chk("fix.sel5.in_ready", 32'(in_ready), 32'h0);
        tick();
        chk_out("fix.sel5.noload", 1'b0, 2'b11, 3'd2);
        // ready in fixed mode is independent of valid
        sel      = 3'd1;
        in_valid = 4'b0000;
        #1 chk("fix.novalid.in_ready", 32'(in_ready), 32'b0010);

        // backpressure: hold ch1 word, ch0 pending
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        tick();
        chk_out("bp.load", 1'b1, 2'd1, 3'd1);
        sel      = 3'd0;
        in_valid = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp.in_ready", 32'(in_ready), 32'h0);
            tick();
            chk_out("bp.hold", 1'b1, 2'd1, 3'd1);
        end
        out_ready = 1'b1;
        #1 chk("bp.release.in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("bp.nobubble", 1'b1, 2'd2, 3'd0);
        in_valid = 4'b0000;
        tick();
        chk_out("bp.drain", 1'b0, 2'd2, 3'd0);

        // round-robin fairness from ptr=0
        mode     = 1'b1;
        in_data  = {2'd3, 2'd2, 2'd1, 2'd0};
        in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk_out($sformatf("rr.fair%0d", k), 1'b1, WIDTH'(k % 4), SELW'(k % 4));
        end
        // ptr=1, only ch1 valid -> grant 1, ptr becomes 2
        in_valid = 4'b0010;
        tick();
        chk_out("rr.to_ptr2", 1'b1, 2'd1, 3'd1);
        // skip/wrap from ptr=2 with ch1 and ch3 valid
        in_valid = 4'b1010;
        tick();
        chk_out("rr.skip3", 1'b1, 2'd3, 3'd3);
        tick();
        chk_out("rr.wrap1", 1'b1, 2'd1, 3'd1);
        // ptr back at 2: ch2 wins over ch1 and ch3
        in_valid = 4'b1110;
        tick();
        chk_out("rr.ptr2again", 1'b1, 2'd2, 3'd2);

        // mode switch at ptr=3
        mode     = 1'b0;
        sel      = 3'd0;
        in_valid = 4'b1111;
        #1 chk("sw.fixed.in_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("sw.fixed", 1'b1, 2'd0, 3'd0);
        mode = 1'b1;
        #1 chk("sw.rr.in_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("sw.rr", 1'b1, 2'd3, 3'd3);
        tick();
        chk_out("sw.rr.next", 1'b1, 2'd0, 3'd0);
        tick();
        chk_out("pre_rst", 1'b1, 2'd1, 3'd1);

        // asynchronous reset mid-stream with ptr=2
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 2'd0, 3'd0);
        chk("arst.in_ready", 32'(in_ready), 32'h0);
        tick();
        rst_n = 1'b1;
        #1 chk("post_rst.in_ready", 32'(in_ready), 32'b0001);
        out_ready = 1'b1;
        tick();
        chk_out("post_rst.first", 1'b1, 2'd0, 3'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
